// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexes N_DIGITS 4-bit display codes onto one shared seven-segment
// decoder and drives the active-low digit anodes. The host writes a display
// word into a pending buffer. That word is copied into the active buffer only
// when the scan wraps from the last digit back to digit 0, so a frame never
// shows a mix of old and new digits. Each digit slot starts with BLANK_CYC
// cycles with every anode off. This hides ghosting while the decoder settles
// on the new code.
//
// Parameters
//   N_DIGITS   number of multiplexed digits (2..16)
//   DIV        clk cycles per digit slot (>= 2)
//   BLANK_CYC  dark cycles at the start of each slot (0 <= BLANK_CYC < DIV)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   digits_in   display codes, digit i = digits_in[4i+3:4i]
//   dp_in       decimal points, active-high, bit i = digit i
//   digit_en    per-digit enable, sampled live (0 = digit kept dark)
//   load        1-cycle strobe: capture digits_in/dp_in into pending buffer
//   pending     captured word not yet committed to the display
//   bcd_out     code of the scanned digit, to the decoder BCD input
//   dp_out      active-low decimal point of the scanned digit
//   anode_n     active-low one-hot digit select (all ones = dark)
//   frame_done  1-cycle pulse after the last slot of a frame ends
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
    parameter int N_DIGITS  = 8,
    parameter int DIV       = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  load,
    output logic                  pending,
    output logic [3:0]            bcd_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   anode_n,
    output logic                  frame_done
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(N_DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    // Display word layout matches {dp_in, digits_in}.
    typedef struct packed {
        logic [N_DIGITS-1:0]   dp;
        logic [4*N_DIGITS-1:0] code;
    } word_t;

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    word_t               active_q, active_d;
    word_t               pend_buf_q, pend_buf_d;
    logic                pending_q, pending_d;
    logic [3:0]          bcd_out_q, bcd_out_d;
    logic                dp_out_q, dp_out_d;
    logic [N_DIGITS-1:0] anode_n_q, anode_n_d;
    logic                frame_done_q, frame_done_d;

    logic tick;
    logic wrap;
    logic slot_lit;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        tick = (presc_q == PRESC_LAST);
        wrap = tick && (idx_q == IDX_LAST);

        presc_d = tick ? '0 : presc_q + PW'(1);

        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end

        // Commit takes the pending word as it was before this edge. A load
        // in the same cycle still lands in the pending buffer and stays
        // pending for the next frame.
        active_d   = active_q;
        pend_buf_d = pend_buf_q;
        pending_d  = pending_q;
        if (wrap && pending_q) begin
            active_d  = pend_buf_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pend_buf_d = {dp_in, digits_in};
            pending_d  = 1'b1;
        end

        // The outputs come from the current idx/presc and are registered,
        // so they lag the scan position by one cycle.
        bcd_out_d = active_q.code[{idx_q, 2'b00} +: 4];
        dp_out_d  = ~active_q.dp[idx_q];

        slot_lit  = (BLANK_CYC == 0) || (presc_q >= BLANK_END);
        anode_n_d = '1;
        if (slot_lit && digit_en[idx_q]) begin
            anode_n_d[idx_q] = 1'b0;
        end

        frame_done_d = wrap;
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the pre-edge value of every other flop.
    // NOTE: the pending and active buffers are reset as well. After reset
    // the display shows zeros, not power-up garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            pend_buf_q   <= '0;
            pending_q    <= 1'b0;
            bcd_out_q    <= 4'h0;
            dp_out_q     <= 1'b1;
            anode_n_q    <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pend_buf_q   <= pend_buf_d;
            pending_q    <= pending_d;
            bcd_out_q    <= bcd_out_d;
            dp_out_q     <= dp_out_d;
            anode_n_q    <= anode_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pending    = pending_q;
    assign bcd_out    = bcd_out_q;
    assign dp_out     = dp_out_q;
    assign anode_n    = anode_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Main instance: N_DIGITS=4, DIV=4, BLANK_CYC=1 (16-cycle frame).
// Second instance: DIV=2, BLANK_CYC=0, all digits enabled, no loads.
//
// The reference model counts cycles since reset and derives the slot and
// phase from that count with division and modulo. It keeps the shown and
// pending words as plain variables. Each clock edge pushes one expected
// output set per instance into a queue. A monitor on the falling edge pops
// the queue and compares the entry against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = N * DIV;
    localparam int DIV6   = 2;
    localparam int FRAME6 = N * DIV6;

    typedef struct {
        logic [3:0] bcd;
        logic       dp;
        logic [3:0] an;
        logic       fd;
        logic       pend;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en;
    logic          load;
    logic          pending;
    logic [3:0]    bcd_out;
    logic          dp_out;
    logic [3:0]    anode_n;
    logic          frame_done;

    logic [15:0]   digits6   = 16'h0000;
    logic [3:0]    dp6       = 4'h0;
    logic [3:0]    en6       = 4'hf;
    logic          load6     = 1'b0;
    logic          pending6;
    logic [3:0]    bcd6;
    logic          dpo6;
    logic [3:0]    anode6;
    logic          fd6;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];
    exp_t exp6_q[$];

    // Reference model state
    bit          started = 1'b0;
    int          t  = 0;
    int          t6 = 0;
    logic [15:0] m_code, m_pcode;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pending;

    always #5 clk = ~clk;

    seven_segment_scanner #(.N_DIGITS(N), .DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .load(load), .pending(pending),
        .bcd_out(bcd_out), .dp_out(dp_out), .anode_n(anode_n),
        .frame_done(frame_done)
    );

    seven_segment_scanner #(.N_DIGITS(N), .DIV(DIV6), .BLANK_CYC(0)) dut6 (
        .clk(clk), .rst(rst), .digits_in(digits6), .dp_in(dp6),
        .digit_en(en6), .load(load6), .pending(pending6),
        .bcd_out(bcd6), .dp_out(dpo6), .anode_n(anode6),
        .frame_done(fd6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // One reference step per rising edge. The expected outputs after the edge
    // come from the state before the edge.
    task automatic model_step();
        exp_t e, e6;
        int   slot, ph, slot6;
        if (rst) begin
            e.bcd = 4'h0; e.dp = 1'b1; e.an = 4'hf; e.fd = 1'b0; e.pend = 1'b0;
            e6 = e;
            t = 0; t6 = 0;
            m_code = '0; m_dp = '0; m_pcode = '0; m_pdp = '0; m_pending = 1'b0;
            started = 1'b1;
        end else if (started) begin
            slot  = (t / DIV) % N;
            ph    = t % DIV;
            e.bcd = m_code[slot*4 +: 4];
            e.dp  = ~m_dp[slot];
            e.an  = 4'hf;
            if (ph >= BLANK && digit_en[slot]) e.an[slot] = 1'b0;
            e.fd  = ((t % FRAME) == FRAME - 1);
            if (((t % FRAME) == FRAME - 1) && m_pending) begin
                m_code = m_pcode; m_dp = m_pdp; m_pending = 1'b0;
            end
            if (load) begin
                m_pcode = digits_in; m_pdp = dp_in; m_pending = 1'b1;
            end
            e.pend = m_pending;
            t++;

            slot6   = (t6 / DIV6) % N;
            e6.bcd  = 4'h0;
            e6.dp   = 1'b1;
            e6.an   = 4'hf;
            e6.an[slot6] = 1'b0;
            e6.fd   = ((t6 % FRAME6) == FRAME6 - 1);
            e6.pend = 1'b0;
            t6++;
        end
        if (started) begin
            exp_q.push_back(e);
            exp6_q.push_back(e6);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: pops the expected entries and compares them against the outputs.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bcd_out",    32'(bcd_out),    32'(e.bcd));
            check("dp_out",     32'(dp_out),     32'(e.dp));
            check("anode_n",    32'(anode_n),    32'(e.an));
            check("frame_done", 32'(frame_done), 32'(e.fd));
            check("pending",    32'(pending),    32'(e.pend));
        end
        if (exp6_q.size() > 0) begin
            e = exp6_q.pop_front();
            check("nb_anode_n",    32'(anode6), 32'(e.an));
            check("nb_frame_done", 32'(fd6),    32'(e.fd));
            check("nb_bcd_dp",     32'({bcd6, dpo6, pending6}), 32'({e.bcd, e.dp, e.pend}));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] code, input logic [3:0] dp);
        digits_in = code;
        dp_in     = dp;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Waits until the next rising edge is frame position ph.
    task automatic wait_phase(input int ph);
        int n = 0;
        while ((t % FRAME) != ph && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("wait_phase_timeout", 32'(t % FRAME), 32'(ph));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; digit_en = 4'hf;
        cyc(2);
        rst = 1'b0;
        cyc(36);

        // Mid-frame load; it is shown from the next frame on.
        wait_phase(5);
        do_load(16'h4321, 4'b0100);
        cyc(40);

        // Two loads in one frame: only the second is ever shown.
        wait_phase(2);
        do_load(16'hABCD, 4'b0001);
        cyc(3);
        do_load(16'h1111, 4'b0000);
        cyc(40);

        // A load on the wrapping edge: the older pending word commits first.
        wait_phase(8);
        do_load(16'h9ABC, 4'b0010);
        wait_phase(15);
        do_load(16'h5678, 4'b1000);
        cyc(40);

        // Disabled digits stay dark.
        digit_en = 4'b1010;
        cyc(20);
        digit_en = 4'hf;

        // Reset mid-slot 2 together with a load.
        wait_phase(9);
        rst = 1'b1; load = 1'b1; digits_in = 16'hFFFF; dp_in = 4'hf;
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        cyc(20);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(7) == 0);
            digits_in = 16'($urandom);
            dp_in = 4'($urandom);
            if (i % 37 == 0) digit_en = 4'($urandom);
            @(negedge clk);
        end
        load = 1'b0;
        cyc(3);

        check("exp_queue_drained", 32'(exp_q.size() + exp6_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
